// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter with a busy/accept handshake for gapless word streaming.
// Build option: define SER_TX_LSB_FIRST_EN to send LSB-first instead of MSB-first.
module ser_tx #(
  parameter int SER_W = 8,
  parameter int CNT_W = $clog2(SER_W)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [SER_W-1:0] data_i,
  input  logic [CNT_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CNT_W:0] FULL_CNT = (CNT_W+1)'(SER_W - 1);
  localparam logic [CNT_W:0] ONE_CNT  = (CNT_W+1)'(1);

  logic [0:0]       state;
  logic [SER_W-1:0] shreg_p0;
  logic [CNT_W:0]   cnt_p0;
  logic [CNT_W:0]   load_cnt;
  logic             accept;

  function automatic logic first_bit(input logic [SER_W-1:0] w);
`ifdef SER_TX_LSB_FIRST_EN
    return w[0];
`else
    return w[SER_W-1];
`endif
  endfunction

  function automatic logic [SER_W-1:0] shift_word(input logic [SER_W-1:0] w);
`ifdef SER_TX_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  // busy_o is registered, so acceptance is possible on the last bit of a burst.
  assign accept   = data_val_i && !busy_o;
  assign load_cnt = (data_mod_i == '0) ? FULL_CNT : ({1'b0, data_mod_i} - ONE_CNT);

  // cnt_p0 counts bits remaining after the one currently on ser_data_o.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      shreg_p0       <= '0;
      cnt_p0         <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (accept) begin
      state          <= SEND;
      shreg_p0       <= shift_word(data_i);
      cnt_p0         <= load_cnt;
      ser_data_o     <= first_bit(data_i);
      ser_data_val_o <= 1'b1;
      busy_o         <= (load_cnt != '0);
    end else if (state == SEND && cnt_p0 != '0) begin
      shreg_p0       <= shift_word(shreg_p0);
      cnt_p0         <= cnt_p0 - ONE_CNT;
      ser_data_o     <= first_bit(shreg_p0);
      ser_data_val_o <= 1'b1;
      busy_o         <= (cnt_p0 != ONE_CNT);
    end else begin
      state          <= IDLE;
      cnt_p0         <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: table of single-word bursts plus hand-written streaming,
// ignore-while-busy and mid-burst reset sequences.
module tb_ser_tx;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] data;
  logic [2:0] mod;
  logic       dval;
  logic       sdata;
  logic       sval;
  logic       busy;

  int total = 0;
  int bad   = 0;

  ser_tx #(.SER_W(8)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (data),
    .data_mod_i     (mod),
    .data_val_i     (dval),
    .ser_data_o     (sdata),
    .ser_data_val_o (sval),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] m;
    int         len;
    logic [7:0] seq;   // seq[7-k] is expected burst bit k
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", nm, k, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_idle_val"}, 0, 32'(sval), 32'd0);
    chk({nm, "_idle_busy"}, 0, 32'(busy), 32'd0);
    chk({nm, "_idle_data"}, 0, 32'(sdata), 32'd0);
  endtask

  task automatic run_vec(input logic [7:0] d, input logic [2:0] m, input int len,
                         input logic [7:0] seq, input string nm);
    data = d;
    mod  = m;
    dval = 1'b1;
    tick();
    dval = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk({nm, "_val"}, k, 32'(sval), 32'd1);
      chk({nm, "_bit"}, k, 32'(sdata), 32'(seq[7-k]));
      chk({nm, "_busy"}, k, 32'(busy), 32'(k < len - 1));
      tick();
    end
    chk_idle(nm);
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  seq18;
    logic [7:0]  seqc3;

    srst = 1'b1;
    dval = 1'b0;
    data = '0;
    mod  = '0;
    repeat (3) tick();
    srst = 1'b0;
    chk_idle("reset");

`ifdef SER_TX_LSB_FIRST_EN
    vecs[0] = '{d: 8'hA5, m: 3'd0, len: 8, seq: 8'hA5};
    vecs[1] = '{d: 8'h01, m: 3'd1, len: 1, seq: 8'h80};
    vecs[2] = '{d: 8'h0F, m: 3'd3, len: 3, seq: 8'hE0};
    vecs[3] = '{d: 8'h3C, m: 3'd5, len: 5, seq: 8'h38};
    vecs[4] = '{d: 8'h0E, m: 3'd0, len: 8, seq: 8'h70};
    vecs[5] = '{d: 8'h80, m: 3'd1, len: 1, seq: 8'h00};
`else
    vecs[0] = '{d: 8'hA5, m: 3'd0, len: 8, seq: 8'hA5};
    vecs[1] = '{d: 8'hF0, m: 3'd3, len: 3, seq: 8'hE0};
    vecs[2] = '{d: 8'h80, m: 3'd1, len: 1, seq: 8'h80};
    vecs[3] = '{d: 8'h3C, m: 3'd5, len: 5, seq: 8'h38};
    vecs[4] = '{d: 8'h0E, m: 3'd0, len: 8, seq: 8'h0E};
    vecs[5] = '{d: 8'h5A, m: 3'd7, len: 7, seq: 8'h5A};
`endif

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i].d, vecs[i].m, vecs[i].len, vecs[i].seq, $sformatf("vec%0d", i));
      tick();
    end

    // Gapless streaming: 8'h81 then 8'h7E with data_val held high.
`ifdef SER_TX_LSB_FIRST_EN
    stream = 16'b1000_0001_0111_1110;
`else
    stream = 16'b1000_0001_0111_1110;
`endif
    data = 8'h81;
    mod  = 3'd0;
    dval = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("stream_val", k, 32'(sval), 32'd1);
      chk("stream_bit", k, 32'(sdata), 32'(stream[15-k]));
      chk("stream_busy", k, 32'(busy), 32'(k != 7 && k != 15));
      if (k == 7) data = 8'h7E;
      if (k == 8) dval = 1'b0;
      tick();
    end
    chk_idle("stream");
    tick();

    // Word offered while busy is dropped; the running burst is untouched.
    seq18 = 8'h18;
    data = 8'h18;
    mod  = 3'd0;
    dval = 1'b1;
    tick();
    dval = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("ignore_val", k, 32'(sval), 32'd1);
      chk("ignore_bit", k, 32'(sdata), 32'(seq18[7-k]));
      chk("ignore_busy", k, 32'(busy), 32'(k < 7));
      if (k == 2) begin
        data = 8'hFF;
        dval = 1'b1;
      end
      if (k == 4) dval = 1'b0;
      tick();
    end
    chk_idle("ignore");
    tick();

    // Reset on the 4th bit of 8'hC3, with a coincident data_val that must be refused.
    seqc3 = 8'hC3;
    data = 8'hC3;
    mod  = 3'd0;
    dval = 1'b1;
    tick();
    dval = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_val", k, 32'(sval), 32'd1);
      chk("rst_bit", k, 32'(sdata), 32'(seqc3[7-k]));
      if (k < 3) tick();
    end
    srst = 1'b1;
    data = 8'hFF;
    dval = 1'b1;
    tick();
    srst = 1'b0;
    dval = 1'b0;
    chk_idle("rst_after");
    tick();
    chk_idle("rst_noaccept");
    run_vec(8'hA5, 3'd0, 8, 8'hA5, "rst_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ser_tx.md
Name: ser_tx

Overview:
- Parallel-to-serial converter. Sits directly upstream of the deserializer core and drives its serial data/valid inputs.
- Accepts one parallel word plus a bit-count per handshake and emits the selected bits one per clock, MSB-first by default.
- Uses an explicit busy/accept handshake so back-to-back words stream with no idle cycle between them.

Parameters:
- SER_W, 8, parallel word width in bits (>= 2); set equal to the downstream deserializer word width for full-word framing.
- CNT_W, $clog2(SER_W), width of data_mod_i (derived; do not override).

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  SER_W  parallel word to serialize.
- data_mod_i  input  CNT_W  number of bits to send; 0 means all SER_W bits; N in 1..SER_W-1 means the N most significant bits.
- data_val_i  input  1  word valid; sampled only when busy_o is 0.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  high on every cycle in which ser_data_o carries a payload bit.
- busy_o  output  1  high while a word is in flight and not on its last bit; new words are refused while high.

Behaviour:
- Interface: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values: ser_data_o=0, ser_data_val_o=0, busy_o=0. Shift register and bit counter cleared.
- Acceptance: a word is accepted on a posedge where data_val_i=1 and busy_o=0. data_i and data_mod_i are captured at that edge.
- data_val_i while busy_o=1: ignored; the word is lost and there is no error flag.
- Length: L = SER_W if data_mod_i==0, else L = data_mod_i.
- Latency: first bit appears on ser_data_o with ser_data_val_o=1 in the cycle after the accepting edge. The remaining bits follow on consecutive cycles, with no gaps, for L cycles total.
- Bit order: bit k of the burst (k=0..L-1) is data_i[SER_W-1-k].
- busy_o=1 during bits 0..L-2 of a burst and 0 during bit L-1. For L=1, busy_o stays 0.
- Gapless streaming: a word accepted on the edge that ends bit L-1 starts its first bit in the next cycle. ser_data_val_o therefore stays high across word boundaries.
- Idle: ser_data_val_o=0 and ser_data_o=0; there are no stale bits on the data line.
- States:
  - IDLE -> SEND on accept.
  - SEND stays in SEND while the counter is non-zero.
  - SEND on the last bit goes to SEND if a new word is accepted, else to IDLE.
- Counter: down-counter of CNT_W+1 bits loaded with L-1. It decrements each SEND cycle; 0 marks the last bit. There is no wrap-around: the counter is reloaded or the block returns to IDLE.
- Reset mid-burst: the burst is aborted and remaining bits are dropped. All outputs are 0 in the cycle after the reset edge. A data_val_i coincident with srst_i is not accepted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SER_TX_LSB_FIRST_EN.
- Defined: bit k of the burst is data_i[k] (LSB-first); data_mod_i=N selects the N least significant bits.
- Not defined: MSB-first as above.
- Handshake, timing and length rules are identical in both builds.

Test Plan (SER_W=8 unless noted):
- Reset, then data_i=8'hA5, data_mod_i=0, data_val_i pulsed one cycle -> ser_data_o=1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after the accept edge. ser_data_val_o high for exactly those 8 cycles; busy_o high for the first 7 of them.
- data_i=8'hF0, data_mod_i=3 -> bits 1,1,1; ser_data_val_o high for 3 cycles; busy_o high for 2.
- data_val_i held high with 8'h81 then 8'h7E (mod 0), second word presented when busy_o falls -> 16 contiguous valid cycles carrying 1000_0001_0111_1110, with no gap.
- data_val_i=1 with 8'hFF while busy_o=1 -> word ignored; the output continues the current burst unchanged.
- srst_i asserted on the 4th bit of 8'hC3 -> next cycle ser_data_val_o=0, busy_o=0, ser_data_o=0. A fresh word accepted afterwards serializes correctly from its bit 0.
- data_mod_i=1 with 8'h80 -> a single bit 1 with busy_o never high. With SER_TX_LSB_FIRST_EN defined, 8'h01 with mod 1 gives a single bit 1, and 8'hA5 with mod 0 gives 1,0,1,0,0,1,0,1 (LSB-first).
